// File: rtl/jpeg_zz_pkg.sv
// -----------------------------------------------------------------------------
// jpeg_zz_pkg
// Shared constants, types and the zigzag lookup for the JPEG coefficient
// reorder path.
//   BLK_SIZE : coefficients per 8x8 block
//   IDX_W    : width of an index within a block
//   idx_t    : index within a block, 0..63
//   zz_addr  : zigzag sequence position -> raster address (row*8+col)
// The coefficient type is parameterised by DATA_W, so it is declared as
// coef_t inside the module that owns DATA_W.
// -----------------------------------------------------------------------------
package jpeg_zz_pkg;

  localparam int BLK_SIZE = 64;
  localparam int IDX_W    = 6;

  typedef logic [IDX_W-1:0] idx_t;

  // Entry n is the raster address of the n-th coefficient in zigzag order.
  localparam idx_t ZZ_ROM [BLK_SIZE] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  function automatic idx_t zz_addr(input idx_t idx);
    return ZZ_ROM[idx];
  endfunction

endpackage

// File: rtl/zz_bank_ctrl.sv
// -----------------------------------------------------------------------------
// zz_bank_ctrl
// Bank bookkeeping for the zigzag reorder buffer: write/read bank pointers,
// in-block write/read counters, per-bank full flags and the full-bank count.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid          upstream coefficient valid
//   out_valid         current state of the output register (owned by the top)
//   out_ready         downstream accept
//   in_ready          write bank is not full (registered state only)
//   wr_en             a coefficient is accepted this cycle
//   rd_load           the output register loads a coefficient this cycle
//   wbank, wcnt       bank / index being written
//   rbank, rcnt       bank / index being read
//   blk_count         number of full banks
// -----------------------------------------------------------------------------
module zz_bank_ctrl
  import jpeg_zz_pkg::*;
#(
  parameter  int NUM_BANKS = 2,
  localparam int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
  localparam int CNT_W     = $clog2(NUM_BANKS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              out_valid,
  input  logic              out_ready,
  output logic              in_ready,
  output logic              wr_en,
  output logic              rd_load,
  output logic [BANK_W-1:0] wbank,
  output idx_t              wcnt,
  output logic [BANK_W-1:0] rbank,
  output idx_t              rcnt,
  output logic [CNT_W-1:0]  blk_count
);

  localparam idx_t LAST_IDX = idx_t'(BLK_SIZE - 1);

  logic [NUM_BANKS-1:0] full;
  logic [NUM_BANKS-1:0] set_mask;
  logic [NUM_BANKS-1:0] clr_mask;

  function automatic logic [BANK_W-1:0] next_bank(input logic [BANK_W-1:0] b);
    return (b == BANK_W'(NUM_BANKS - 1)) ? '0 : b + BANK_W'(1);
  endfunction

  assign in_ready = !full[wbank];
  assign wr_en    = in_valid && in_ready;
  // The output register can take a beat when it is empty or being emptied.
  assign rd_load  = full[rbank] && (!out_valid || out_ready);

  // A write can only complete into a non-full bank and a read can only
  // finish a full one, so set and clear never target the same bank.
  always_comb begin
    // NOTE: every always_comb output gets a default first; a path that leaves
    // a signal unassigned would infer a latch.
    set_mask = '0;
    clr_mask = '0;
    if (wr_en && (wcnt == LAST_IDX))   set_mask[wbank] = 1'b1;
    if (rd_load && (rcnt == LAST_IDX)) clr_mask[rbank] = 1'b1;
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbank <= '0;
      wcnt  <= '0;
      rbank <= '0;
      rcnt  <= '0;
      full  <= '0;
    end else begin
      if (wr_en) begin
        wcnt <= wcnt + idx_t'(1);
        if (wcnt == LAST_IDX) wbank <= next_bank(wbank);
      end
      if (rd_load) begin
        rcnt <= rcnt + idx_t'(1);
        if (rcnt == LAST_IDX) rbank <= next_bank(rbank);
      end
      full <= (full & ~clr_mask) | set_mask;
    end
  end

  always_comb begin
    blk_count = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      blk_count = blk_count + CNT_W'(full[i]);
    end
  end

endmodule

// File: rtl/zigzag_reorder_pp.sv
// -----------------------------------------------------------------------------
// zigzag_reorder_pp
// Multi-bank 8x8 coefficient reorder buffer. Blocks arrive in raster order on
// a valid/ready stream and leave in JPEG zigzag order, or unchanged when the
// block was tagged as bypass on its first coefficient. With two or more banks
// one block fills while another drains.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   in_valid     input coefficient valid
//   in_ready     input accepted when in_valid && in_ready
//   in_data      coefficient in raster order
//   in_zz        block mode, sampled with coefficient 0: 1 zigzag, 0 raster
//   out_valid    output register holds data
//   out_ready    downstream accept
//   out_data     reordered coefficient
//   out_idx      sequence index within the block
//   out_last     high with out_idx == 63
//   blk_count    number of full banks awaiting readout
// -----------------------------------------------------------------------------
module zigzag_reorder_pp
  import jpeg_zz_pkg::*;
#(
  parameter  int DATA_W    = 12,
  parameter  int NUM_BANKS = 2,
  localparam int CNT_W     = $clog2(NUM_BANKS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_zz,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last,
  output logic [CNT_W-1:0]  blk_count
);

  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  typedef logic [DATA_W-1:0] coef_t;

  coef_t                mem [NUM_BANKS][BLK_SIZE];
  logic [NUM_BANKS-1:0] mode;

  logic              wr_en;
  logic              rd_load;
  logic [BANK_W-1:0] wbank;
  logic [BANK_W-1:0] rbank;
  idx_t              wcnt;
  idx_t              rcnt;
  idx_t              rd_addr;

  zz_bank_ctrl #(
    .NUM_BANKS (NUM_BANKS)
  ) u_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .in_ready  (in_ready),
    .wr_en     (wr_en),
    .rd_load   (rd_load),
    .wbank     (wbank),
    .wcnt      (wcnt),
    .rbank     (rbank),
    .rcnt      (rcnt),
    .blk_count (blk_count)
  );

  // NOTE: the storage array and mode bits are deliberately not reset. A bank
  // is only read after all 64 entries and its mode have been written, so the
  // power-up contents are never observed, and leaving out the reset lets the
  // array map onto RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wbank][wcnt] <= in_data;
      if (wcnt == '0) mode[wbank] <= in_zz;
    end
  end

  assign rd_addr = mode[rbank] ? zz_addr(rcnt) : rcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
    end else if (rd_load) begin
      out_valid <= 1'b1;
      out_data  <= mem[rbank][rd_addr];
      out_idx   <= rcnt;
      out_last  <= (rcnt == idx_t'(BLK_SIZE - 1));
    end else if (out_ready) begin
      // Beat taken with nothing to replace it.
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_zigzag_reorder_pp.sv
// -----------------------------------------------------------------------------
// tb_zigzag_reorder_pp
// Directed bench for zigzag_reorder_pp: a two-bank instance covers zigzag,
// bypass, back-to-back blocks, backpressure and mid-block reset; a one-bank
// instance covers the half-rate stall window.
// -----------------------------------------------------------------------------
module tb_zigzag_reorder_pp;

  typedef struct packed {
    logic [11:0] d;
    logic        zz;
  } in_t;

  typedef struct packed {
    logic [11:0] d;
    logic [5:0]  idx;
  } exp_t;

  int zz_tab [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };

  logic        clk;
  logic        rst_n;

  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_data;
  logic        in_zz;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_data;
  logic [5:0]  out_idx;
  logic        out_last;
  logic [1:0]  blk_count;

  logic        i1_valid;
  logic        i1_ready;
  logic [11:0] i1_data;
  logic        i1_zz;
  logic        o1_valid;
  logic        o1_ready;
  logic [11:0] o1_data;
  logic [5:0]  o1_idx;
  logic        o1_last;
  logic [0:0]  bc1;

  int   n_cmp;
  int   n_fail;
  int   acc_cnt;
  logic rdy_drop;
  in_t  in_q [$];
  exp_t exp_q [$];

  zigzag_reorder_pp #(.DATA_W(12), .NUM_BANKS(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_zz     (in_zz),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .blk_count (blk_count)
  );

  zigzag_reorder_pp #(.DATA_W(12), .NUM_BANKS(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (i1_valid),
    .in_ready  (i1_ready),
    .in_data   (i1_data),
    .in_zz     (i1_zz),
    .out_valid (o1_valid),
    .out_ready (o1_ready),
    .out_data  (o1_data),
    .out_idx   (o1_idx),
    .out_last  (o1_last),
    .blk_count (bc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present the head of the input queue to the two-bank instance.
  task automatic drive();
    in_valid = (in_q.size() > 0);
    in_data  = in_valid ? in_q[0].d  : 12'h000;
    in_zz    = in_valid ? in_q[0].zz : 1'b0;
  endtask

  // Queue one block of inputs and the beats it must produce.
  task automatic push_block(input logic [11:0] base, input logic zz,
                            input logic toggle, input logic konst);
    in_t  it;
    exp_t e;
    for (int i = 0; i < 64; i++) begin
      it.d  = konst ? base : base + 12'(i);
      it.zz = (i == 0) ? zz : (toggle ? ~zz : zz);
      in_q.push_back(it);
    end
    for (int k = 0; k < 64; k++) begin
      e.idx = 6'(k);
      e.d   = konst ? base : base + 12'(zz ? zz_tab[k] : k);
      exp_q.push_back(e);
    end
  endtask

  // One clock on the two-bank instance: score the beat and the accept that
  // the coming edge will perform, then advance to the next falling edge.
  task automatic step();
    exp_t e;
    if (in_valid && !in_ready) rdy_drop = 1'b1;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_beat", 32'(out_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("beat", 32'({out_last, out_idx, out_data}),
              32'({(e.idx == 6'd63), e.idx, e.d}));
      end
    end
    if (in_valid && in_ready) begin
      void'(in_q.pop_front());
      acc_cnt++;
    end
    @(posedge clk);
    @(negedge clk);
    drive();
  endtask

  task automatic drain(input int budget, input string tag);
    int n;
    n = 0;
    while ((exp_q.size() > 0 || in_q.size() > 0) && n < budget) begin
      step();
      n++;
    end
    check(tag, 32'(exp_q.size() + in_q.size()), 32'd0);
  endtask

  initial begin
    int n;
    int k;
    logic acc;

    n_cmp     = 0;
    n_fail    = 0;
    acc_cnt   = 0;
    rdy_drop  = 1'b0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_zz     = 1'b0;
    out_ready = 1'b1;
    i1_valid  = 1'b0;
    i1_data   = '0;
    i1_zz     = 1'b0;
    o1_ready  = 1'b1;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_outputs", 32'({out_valid, out_last, out_idx, out_data}), 32'd0);
    check("rst_ready_count", 32'({in_ready, blk_count}), 32'b100);
    check("rst_nb1_ready", 32'({i1_ready, o1_valid, bc1}), 32'b100);
    rst_n = 1'b1;
    @(negedge clk);

    // Zigzag block of 0..63.
    push_block(12'd0, 1'b1, 1'b0, 1'b0);
    drive();
    n = 0;
    while (in_q.size() > 0 && n < 200) begin
      step();
      n++;
    end
    check("t1_all_accepted", 32'(in_q.size()), 32'd0);
    check("t1_no_valid_at_64th", 32'(out_valid), 32'd0);
    check("t1_blk_count", 32'(blk_count), 32'd1);
    step();
    check("t1_first_valid", 32'({out_valid, out_idx, out_data}), 32'({1'b1, 6'd0, 12'd0}));
    drain(200, "t1_drain");

    // Raster bypass of 0..63.
    push_block(12'd0, 1'b0, 1'b0, 1'b0);
    drive();
    drain(300, "t2_drain");

    // Back-to-back zigzag then bypass, mode toggled inside each block.
    rdy_drop = 1'b0;
    push_block(12'd100, 1'b1, 1'b1, 1'b0);
    push_block(12'd200, 1'b0, 1'b1, 1'b0);
    drive();
    drain(400, "t3_drain");
    check("t3_in_ready_held", 32'(rdy_drop), 32'd0);

    // Backpressure: downstream stalled while four blocks are offered.
    out_ready = 1'b0;
    acc_cnt   = 0;
    push_block(12'h100, 1'b1, 1'b0, 1'b0);
    push_block(12'h200, 1'b0, 1'b0, 1'b0);
    push_block(12'h300, 1'b1, 1'b0, 1'b0);
    push_block(12'h400, 1'b0, 1'b0, 1'b0);
    drive();
    repeat (140) step();
    check("t4_accepts_stalled", 32'(acc_cnt), 32'd128);
    check("t4_in_ready_low", 32'(in_ready), 32'd0);
    check("t4_blk_count", 32'(blk_count), 32'd2);
    check("t4_held_beat", 32'({out_valid, out_idx, out_data}), 32'({1'b1, 6'd0, 12'h100}));
    repeat (10) step();
    check("t4_still_held", 32'({out_valid, out_data}), 32'({1'b1, 12'h100}));
    check("t4_accepts_still", 32'(acc_cnt), 32'd128);
    out_ready = 1'b1;
    drain(800, "t4_drain");

    // Reset while one block drains and the next is partly written.
    acc_cnt = 0;
    push_block(12'h600, 1'b1, 1'b0, 1'b0);
    push_block(12'h700, 1'b0, 1'b0, 1'b0);
    drive();
    n = 0;
    while (acc_cnt < 84 && n < 300) begin
      step();
      n++;
    end
    check("t5_accepts_before_rst", 32'(acc_cnt), 32'd84);
    check("t5_draining_before_rst", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_out_valid", 32'(out_valid), 32'd0);
    check("t5_rst_in_ready", 32'(in_ready), 32'd1);
    check("t5_rst_blk_count", 32'(blk_count), 32'd0);
    in_q.delete();
    exp_q.delete();
    drive();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push_block(12'h800, 1'b1, 1'b0, 1'b1);
    drive();
    drain(300, "t5_drain");

    // Single bank: writes stall until the read frees the bank.
    k        = 0;
    i1_valid = 1'b1;
    i1_zz    = 1'b0;
    i1_data  = 12'd0;
    n        = 0;
    while (k < 64 && n < 200) begin
      acc = i1_ready;
      @(posedge clk);
      @(negedge clk);
      if (acc) k++;
      i1_data = 12'(k);
      n++;
    end
    i1_valid = 1'b0;
    check("nb1_accepts", 32'(k), 32'd64);
    check("nb1_ready_after_64th", 32'({i1_ready, o1_valid, bc1}), 32'b001);
    for (int b = 0; b < 64; b++) begin
      @(posedge clk);
      @(negedge clk);
      check("nb1_beat_a", 32'({i1_ready, o1_valid, o1_last, o1_idx, o1_data}),
            32'({(b == 63), 1'b1, (b == 63), 6'(b), 12'(b)}));
    end
    k        = 0;
    i1_valid = 1'b1;
    i1_zz    = 1'b1;
    i1_data  = 12'h500;
    n        = 0;
    while (k < 64 && n < 200) begin
      acc = i1_ready;
      @(posedge clk);
      @(negedge clk);
      if (acc) k++;
      i1_data = 12'h500 + 12'(k);
      n++;
    end
    i1_valid = 1'b0;
    check("nb1_accepts_b", 32'(k), 32'd64);
    for (int b = 0; b < 64; b++) begin
      @(posedge clk);
      @(negedge clk);
      check("nb1_beat_b", 32'({o1_valid, o1_last, o1_idx, o1_data}),
            32'({1'b1, (b == 63), 6'(b), 12'h500 + 12'(zz_tab[b])}));
    end
    @(posedge clk);
    @(negedge clk);
    check("nb1_idle_after", 32'({o1_valid, i1_ready}), 32'b01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/zigzag_reorder_pp.md
Name: zigzag_reorder_pp

Overview:
- Parametrised successor to the zigzag sresult register bank in the JPEG encoder's fdct_zigzag path.
- Accepts 8x8 coefficient blocks in raster order on a valid/ready stream and emits them in JPEG zigzag order.
- Holds NUM_BANKS blocks (ping-pong at the default of 2), so a new block can be written while the previous one drains.
- Adds a per-block bypass mode (raster pass-through) and full backpressure; the old bank had neither.

Parameters:
- DATA_W, 12, coefficient width; data is treated as opaque bits.
- NUM_BANKS, 2, number of 64-entry block buffers; legal range 1..4.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input coefficient valid.
- in_ready  out  1  input accepted when in_valid && in_ready.
- in_data  in  DATA_W  coefficient, raster order (row*8+col).
- in_zz  in  1  mode, sampled with the first coefficient of a block: 1 = zigzag, 0 = raster bypass.
- out_valid  out  1  output register holds data.
- out_ready  in  1  downstream accept.
- out_data  out  DATA_W  reordered coefficient.
- out_idx  out  6  output sequence index 0..63 within the block.
- out_last  out  1  high with out_idx==63.
- blk_count  out  clog2(NUM_BANKS+1)  number of full banks awaiting readout.

Behaviour:
- Reset (async assert, sync-release assumed upstream):
  - wbank=0, wcnt=0, rbank=0, all full flags=0.
  - out_valid=0, out_data=0, out_idx=0, out_last=0, blk_count=0, in_ready=1.
  - Storage array is not reset.
  - Reset mid-block discards all partial and full blocks; the next accepted coefficient is index 0 of a new block.
- Write side:
  - in_ready = !full[wbank]. It is driven only by registered state, with no combinational path from out_ready.
  - On accept: mem[wbank][wcnt] <= in_data.
  - If wcnt==0, mode[wbank] <= in_zz. in_zz is ignored at all other indices.
  - wcnt increments; at wcnt==63 the accept sets full[wbank]=1, wraps wcnt to 0 and advances wbank modulo NUM_BANKS.
- Read side, one output register stage:
  - Load condition: full[rbank] && (!out_valid || out_ready).
  - On load:
    - out_data <= mem[rbank][addr], where addr = ZZ_ROM[rcnt] if mode[rbank] else rcnt.
    - out_idx <= rcnt, out_last <= (rcnt==63), out_valid <= 1.
    - rcnt increments. On rcnt==63, clear full[rbank], wrap rcnt and advance rbank.
  - If out_ready && out_valid and there is no load, out_valid <= 0.
  - Output holds stable while out_valid && !out_ready.
- Latency: the 64th write is accepted at edge t, full is visible in cycle t+1, and out_valid is high from edge t+1 with index 0. First-in to first-out is therefore 65 cycles minimum.
- Throughput:
  - NUM_BANKS>=2: one coefficient per cycle sustained on both sides with out_ready=1.
  - NUM_BANKS=1: half rate; the write stalls until the read frees the bank.
- Simultaneous events:
  - Freeing and filling of different banks in the same cycle are both honoured.
  - A bank freed at edge t is writable from cycle t+1 (in_ready rises at t+1).
  - blk_count always equals popcount(full).
- Full/empty:
  - All banks full -> in_ready=0 indefinitely, no data lost.
  - No bank full -> out_valid falls after the last beat is taken.

Decomposition:
- Package jpeg_zz_pkg:
  - BLK_SIZE=64 and IDX_W=6.
  - Function zz_addr(idx) returning the 64-entry zigzag-to-raster table: 0,1,8,16,9,2,3,10,17,24,32,25,18,11,4,5,...,55,62,63.
  - Typedef coef_t sized by DATA_W at the use site.
- One sub-module, zz_bank_ctrl, holds the wbank/rbank/full-flag/count logic. The top holds the storage array, mode bits and output register.

Test Plan:
- Write 0..63 with in_zz=1, out_ready=1 -> out_data 0,1,8,16,9,2,3,10,17,24,... ending 62,63; out_last only on beat 64; out_valid first seen 1 cycle after the 64th accept.
- Same stimulus with in_zz=0 -> out_data 0..63 in order; out_idx equals out_data.
- Back-to-back blocks A (zz, values 100+i) and B (bypass, values 200+i), in_zz toggled mid-block and ignored -> A zigzag then B raster; in_ready never drops (NUM_BANKS=2).
- out_ready=0, stream 200 coefficients -> in_ready drops after accept 128, blk_count=2, out_data stable at A[0]. Release out_ready -> all 192 reads in correct order, with the stalled third block intact.
- Assert rst_n after 20 writes of block 2 while block 1 drains -> out_valid=0, in_ready=1, blk_count=0 immediately; a new block of value 0x800 (-2048, DATA_W=12) is emitted unmodified 64 times.
- NUM_BANKS=1 -> in_ready low from the 64th accept until the edge loading out_idx 63; the next write lands at index 0.
